// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Optional feature macro: UART_ARB_LOCK_EN (message lock), used by uart_tx_arbiter.
package uart_tx_arbiter_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1,
        WAIT_HI = 2'd2
    } arb_state_t;

    // Longest stay in WAIT_LO when the UART never visibly drops RDY
    localparam int unsigned WAIT_LO_LIMIT = 2;

    // Consecutive IDLE cycles with the lock owner silent before the lock is abandoned
    localparam int unsigned LOCK_TIMEOUT = 256;

    // Index width for an n-entry requester vector (at least one bit)
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester strictly after
// the pointer, in increasing modulo order, as both a one-hot vector and an index.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_width(N)
)
(
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] w_try;

    // Scan ptr+1 .. ptr+N (mod N) and keep the first requester found
    always_comb begin
        o_valid  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        w_try    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_try = IW'((32'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_try]) begin
                o_valid         = 1'b1;
                o_idx           = w_try;
                o_onehot[w_try] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter (DIN/OE/RDY) among several
// byte sources. One byte is issued per grant; the next grant waits until the
// UART has taken the byte and become ready again.
// Optional feature macro: UART_ARB_LOCK_EN -- message lock keyed on LAST,
// with an abandon timeout when the lock owner stops requesting.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned Ports = 2,
    parameter int unsigned Width = 8
)
(
    input  logic                   CLK,
    input  logic                   RST_,
    input  logic [Ports-1:0]       REQ,
    input  logic [Ports*Width-1:0] DATA,
    input  logic [Ports-1:0]       LAST,
    output logic [Ports-1:0]       ACK,
    output logic [Ports-1:0]       GNT,
    output logic                   BUSY,
    output logic [Width-1:0]       DIN,
    output logic                   OE,
    input  logic                   RDY
);

    localparam int unsigned IW = idx_width(Ports);

    arb_state_t       r_state;
    logic [IW-1:0]    r_ptr;
    logic [1:0]       r_wcnt;

    logic [Ports-1:0] w_cand;
    logic             w_valid;
    logic [Ports-1:0] w_onehot;
    logic [IW-1:0]    w_idx;
    logic [Width-1:0] w_wdata;
    logic             w_grant;

`ifdef UART_ARB_LOCK_EN
    logic             r_lock;
    logic [7:0]       r_abandon;
    logic [Ports-1:0] w_owner_mask;

    // One-hot mask of the lock owner, which is always the last winner
    always_comb begin
        w_owner_mask        = '0;
        w_owner_mask[r_ptr] = 1'b1;
    end

    assign w_cand = r_lock ? (REQ & w_owner_mask) : REQ;

    // Message lock: set by a non-final byte, cleared by a final byte or abandonment
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            r_lock    <= 1'b0;
            r_abandon <= '0;
        end else if (w_grant) begin
            r_lock    <= ~LAST[w_idx];
            r_abandon <= '0;
        end else if (r_lock && (r_state == IDLE)) begin
            if (REQ[r_ptr]) begin
                r_abandon <= '0;
            end else if (r_abandon == 8'(LOCK_TIMEOUT - 1)) begin
                r_lock    <= 1'b0;
                r_abandon <= '0;
            end else begin
                r_abandon <= r_abandon + 8'd1;
            end
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = ^LAST;
    assign w_cand        = REQ;
`endif

    rr_pick #(
        .N  (Ports),
        .IW (IW)
    ) u_pick (
        .i_req    (w_cand),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_onehot (w_onehot),
        .o_idx    (w_idx)
    );

    // Byte of the current winner
    always_comb begin
        w_wdata = '0;
        for (int unsigned i = 0; i < Ports; i++) begin
            if (w_idx == IW'(i)) begin
                w_wdata = DATA[i*Width +: Width];
            end
        end
    end

    assign w_grant = (r_state == IDLE) && RDY && w_valid;

    // Control FSM with registered UART strobe, acknowledge, grant and busy flag
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            r_state <= IDLE;
            r_ptr   <= IW'(Ports - 1);
            r_wcnt  <= '0;
            OE      <= 1'b0;
            ACK     <= '0;
            GNT     <= '0;
            BUSY    <= 1'b0;
            DIN     <= '0;
        end else begin
            OE  <= 1'b0;
            ACK <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        DIN     <= w_wdata;
                        OE      <= 1'b1;
                        ACK     <= w_onehot;
                        GNT     <= w_onehot;
                        BUSY    <= 1'b1;
                        r_ptr   <= w_idx;
                        r_wcnt  <= '0;
                        r_state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!RDY || (r_wcnt == 2'(WAIT_LO_LIMIT - 1))) begin
                        r_state <= WAIT_HI;
                    end else begin
                        r_wcnt <= r_wcnt + 2'd1;
                    end
                end
                WAIT_HI: begin
                    if (RDY) begin
                        BUSY    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    BUSY    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (Ports=3, Width=8).
// Expected bytes are queued per requester when presented; a monitor pops and
// compares on every OE, and predicts the winner from the round-robin rule.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int P = 3;
    localparam int W = 8;

    logic           CLK  = 1'b0;
    logic           RST_ = 1'b0;
    logic [P-1:0]   REQ  = '0;
    logic [P-1:0]   LAST = '0;
    logic [P*W-1:0] DATA = '0;
    logic           RDY  = 1'b1;
    logic [P-1:0]   ACK;
    logic [P-1:0]   GNT;
    logic           BUSY;
    logic           OE;
    logic [W-1:0]   DIN;

    uart_tx_arbiter #(.Ports(P), .Width(W)) dut (
        .CLK  (CLK),
        .RST_ (RST_),
        .REQ  (REQ),
        .DATA (DATA),
        .LAST (LAST),
        .ACK  (ACK),
        .GNT  (GNT),
        .BUSY (BUSY),
        .DIN  (DIN),
        .OE   (OE),
        .RDY  (RDY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q [P][$];
    int         seen_w[$];
    logic [7:0] seen_b[$];
    int         model_last = P - 1;
    int         model_lock = -1;
    bit         uart_auto = 1'b0;
    int         uart_busy = 0;
    int         uart_max_busy = 5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: no event within bound at %0t", name, $time);
    endtask

    function automatic logic [P-1:0] onehot(input int i);
        logic [P-1:0] one;
        one = 1;
        return (i < 0) ? '0 : (one << i);
    endfunction

    // Round-robin rule: first requesting index after 'last', increasing modulo P
    function automatic int rr_first(input logic [P-1:0] req, input int last);
        logic [P-1:0] sh;
        for (int k = 1; k <= P; k++) begin
            sh = req >> ((last + k) % P);
            if (sh[0]) return (last + k) % P;
        end
        return -1;
    endfunction

    task automatic present(input int i, input logic [7:0] b, input logic l);
        DATA[i*W +: W] = b;
        LAST[i]        = l;
        REQ[i]         = 1'b1;
        exp_q[i].push_back(b);
    endtask

    task automatic wait_ack(input int i, output bit ok);
        logic [P-1:0] sh;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            sh = ACK >> i;
            if (sh[0] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("ack_wait");
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_oe(input int limit, output int n);
        n = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge CLK);
            if (OE === 1'b1) begin
                n = c;
                break;
            end
        end
        if (n < 0) timeout("oe_wait");
    endtask

    task automatic requester(input int i, input int n, input bit gaps);
        bit ok;
        for (int k = 0; k < n; k++) begin
            present(i, 8'($urandom), 1'b1);
            wait_ack(i, ok);
            if (!ok) break;
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                REQ[i] = 1'b0;
                repeat ($urandom_range(1, 6)) @(posedge CLK);
                #1;
            end
        end
        REQ[i] = 1'b0;
    endtask

    task automatic do_reset();
        uart_auto = 1'b0;
        @(posedge CLK);
        #1;
        RST_ = 1'b0;
        REQ  = '0;
        LAST = '0;
        RDY  = 1'b1;
        uart_busy = 0;
        for (int i = 0; i < P; i++) exp_q[i].delete();
        repeat (2) @(posedge CLK);
        #1;
        RST_ = 1'b1;
        seen_w.delete();
        seen_b.delete();
    endtask

    // Monitor: predicts the winner and byte for every OE from the spec rules
    initial begin : monitor
        logic [P-1:0] req_e, last_e, cand, sh;
        logic         rdy_e, prev_oe;
        int           w;
        prev_oe = 1'b0;
        forever begin
            @(posedge CLK);
            req_e  = REQ;
            last_e = LAST;
            rdy_e  = RDY;
            @(negedge CLK);
            if (!RST_) begin
                model_last = P - 1;
                model_lock = -1;
                prev_oe    = 1'b0;
                continue;
            end
            if (OE === 1'b1) begin
                check("oe_single_cycle", 32'(prev_oe), 0);
                check("oe_needs_rdy", 32'(rdy_e), 1);
                check("busy_on_oe", 32'(BUSY), 1);
                cand = (model_lock >= 0) ? (req_e & onehot(model_lock)) : req_e;
                w = rr_first(cand, model_last);
                check("ack_winner", 32'(ACK), 32'(onehot(w)));
                check("gnt_winner", 32'(GNT), 32'(onehot(w)));
                if (w >= 0 && exp_q[w].size() != 0) begin
                    check("din_byte", 32'(DIN), 32'(exp_q[w].pop_front()));
                    model_last = w;
`ifdef UART_ARB_LOCK_EN
                    sh = last_e >> w;
                    model_lock = sh[0] ? -1 : w;
`endif
                end else begin
                    n_checks++;
                    $display("FAIL unexpected_oe: din 0x%0h ack 0x%0h with no pending byte at %0t", DIN, ACK, $time);
                end
                seen_w.push_back(w);
                seen_b.push_back(DIN);
            end else begin
                check("ack_without_oe", 32'(ACK), 0);
            end
            prev_oe = OE;
        end
    end

    // UART model: after accepting a byte it drops RDY for a random busy time (0 = never drops)
    initial begin : uart
        forever begin
            @(posedge CLK);
            if (uart_auto) begin
                if (OE === 1'b1) begin
                    check("uart_idle_on_oe", 32'(uart_busy), 0);
                    uart_busy = $urandom_range(0, uart_max_busy);
                end else if (uart_busy > 0) begin
                    uart_busy--;
                end
                #1 RDY = (uart_busy == 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n, cnt, acks;
        bit ok;
        logic [7:0] lock_exp [3];

        // Reset values
        RST_ = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_oe", 32'(OE), 0);
        check("rst_ack", 32'(ACK), 0);
        check("rst_gnt", 32'(GNT), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_din", 32'(DIN), 0);
        RST_ = 1'b1;

        // Single requester: one-cycle grant latency
        @(posedge CLK);
        #1;
        RDY = 1'b1;
        present(0, 8'h41, 1'b1);
        @(negedge CLK);
        check("lat_no_oe_same_cycle", 32'(OE), 0);
        @(negedge CLK);
        check("lat_oe", 32'(OE), 1);
        check("lat_ack", 32'(ACK), 32'(3'b001));
        check("lat_din", 32'(DIN), 32'h41);
        @(posedge CLK);
        #1;
        check("oe_one_cycle", 32'(OE), 0);
        RDY = 1'b0;
        present(0, 8'h42, 1'b1);
        cnt = 0;
        repeat (6) begin
            @(negedge CLK);
            cnt += int'(OE);
        end
        check("no_oe_while_rdy_low", 32'(cnt), 0);
        @(posedge CLK);
        #1;
        RDY = 1'b1;
        wait_oe(10, n);
        check("oe_after_rdy_rise", 32'(n > 0), 1);

        // RDY never drops: WAIT_LO exits on its limit
        @(posedge CLK);
        #1;
        present(0, 8'h43, 1'b1);
        wait_oe(20, n);
        check("rdy_stuck_spacing", 32'(n), 4);
        @(posedge CLK);
        #1;
        REQ[0] = 1'b0;
        repeat (6) @(posedge CLK);
        #1;

        // Withdrawn request while RDY low
        RDY = 1'b0;
        DATA[1*W +: W] = 8'h77;
        REQ[1] = 1'b1;
        cnt = 0;
        acks = 0;
        repeat (3) begin
            @(negedge CLK);
            cnt += int'(OE);
            acks += int'(ACK[1]);
        end
        @(posedge CLK);
        #1;
        REQ[1] = 1'b0;
        @(posedge CLK);
        #1;
        RDY = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            cnt += int'(OE);
            acks += int'(ACK[1]);
        end
        check("withdraw_no_oe", 32'(cnt), 0);
        check("withdraw_no_ack", 32'(acks), 0);

        // Round robin with all three requesting continuously
        do_reset();
        uart_max_busy = 3;
        uart_auto = 1'b1;
        fork
            requester(0, 2, 1'b0);
            requester(1, 2, 1'b0);
            requester(2, 2, 1'b0);
        join
        check("rr_count", 32'(seen_w.size()), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < seen_w.size()) check("rr_order", 32'(seen_w[k]), 32'(k % 3));
        end

        // Two-byte message from requester 0 against requester 1
        do_reset();
        uart_auto = 1'b1;
        fork
            begin
                present(0, 8'h41, 1'b0);
                wait_ack(0, ok);
                present(0, 8'h42, 1'b1);
                wait_ack(0, ok);
                REQ[0] = 1'b0;
            end
            begin
                present(1, 8'h43, 1'b1);
                wait_ack(1, ok);
                REQ[1] = 1'b0;
            end
        join
`ifdef UART_ARB_LOCK_EN
        lock_exp = '{8'h41, 8'h42, 8'h43};
`else
        lock_exp = '{8'h41, 8'h43, 8'h42};
`endif
        check("msg_count", 32'(seen_b.size()), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < seen_b.size()) check("msg_order", 32'(seen_b[k]), 32'(lock_exp[k]));
        end

        // Randomized traffic with random UART busy times
        do_reset();
        uart_max_busy = 5;
        uart_auto = 1'b1;
        fork
            requester(0, 15, 1'b1);
            requester(1, 15, 1'b1);
            requester(2, 15, 1'b1);
        join
        repeat (10) @(posedge CLK);
        for (int i = 0; i < P; i++) check("queue_drained", 32'(exp_q[i].size()), 0);

        // Reset during OE
        uart_auto = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RDY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        present(2, 8'h5A, 1'b1);
        wait_oe(10, n);
        #1;
        RST_ = 1'b0;
        #1;
        check("async_rst_oe", 32'(OE), 0);
        check("async_rst_ack", 32'(ACK), 0);
        check("async_rst_gnt", 32'(GNT), 0);
        REQ = '0;
        for (int i = 0; i < P; i++) exp_q[i].delete();
        repeat (2) @(posedge CLK);
        #1;
        RST_ = 1'b1;
        @(negedge CLK);
        check("post_rst_busy", 32'(BUSY), 0);
        check("post_rst_din", 32'(DIN), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
